// File: rtl/multiplier_pkg.sv
// Shared constants, FSM encoding and timing helper for the TDM audio multiplier.
package multiplier_pkg;

  localparam logic [1:0] MODE_RING   = 2'b00;
  localparam logic [1:0] MODE_AM     = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;
  localparam logic [1:0] MODE_MUTE   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_WRITE,
    ST_PUBLISH
  } state_e;

  // Number of clk cycles from the first busy cycle to the out_valid pulse.
  function automatic int unsigned latency(input int unsigned bitsize,
                                          input int unsigned channels);
    return channels * (bitsize + 2) + 1;
  endfunction

endpackage

// File: rtl/multiplier_tdm_if.sv
// Sample-side bundle of the TDM multiplier: frame clock, operands, modes and results.
interface multiplier_tdm_if #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
);
  logic                         lrclk;
  logic [CHANNELS*BITSIZE-1:0]  in1;
  logic [CHANNELS*BITSIZE-1:0]  in2;
  logic [2*CHANNELS-1:0]        mode;
  logic                         clear_overrun;
  logic [CHANNELS*BITSIZE-1:0]  out;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output lrclk, in1, in2, mode, clear_overrun,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  lrclk, in1, in2, mode, clear_overrun,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/serial_umul.sv
// Radix-2 shift-add unsigned multiplier; one partial product per cycle, fixed BITSIZE-cycle run.
module serial_umul #(
  parameter int BITSIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [BITSIZE-1:0]     a,
  input  logic [BITSIZE-1:0]     b,
  output logic                   done,
  output logic [2*BITSIZE-1:0]   product
);
  localparam int CW = $clog2(BITSIZE + 1);

  logic [2*BITSIZE-1:0] mcand_q;
  logic [BITSIZE-1:0]   mplier_q;
  logic [CW-1:0]        cnt_q;

  // Load clears the accumulator; each following cycle consumes one multiplier bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      product  <= '0;
      mcand_q  <= {{BITSIZE{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(BITSIZE);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) product <= product + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  // Terminal count: the last partial product lands on this edge.
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/multiplier_tdm.sv
// Time-multiplexed multi-channel multiplier: one shared shift-add core, per-channel mode,
// results published atomically once per lrclk frame.
module multiplier_tdm
  import multiplier_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2
) (
  input logic              clk,
  input logic              reset,
  multiplier_tdm_if.slave  bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic signed [2*BITSIZE:0] SAT_MAX = {{(BITSIZE+2){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [2*BITSIZE:0] SAT_MIN = ~SAT_MAX;

  state_e state_q, state_d;
  logic   s1_q, s2_q, s3_q, start;
  logic   umul_load, umul_done, last_ch;
  logic [2*BITSIZE-1:0] product;

  logic [CHANNELS-1:0][BITSIZE-1:0] in1_q, in2_q, res_q;
  logic [CHANNELS-1:0][1:0]         mode_q;
  logic [CH_W-1:0]                  ch_q;
  logic [CHANNELS*BITSIZE-1:0]      out_q;
  logic                             out_valid_q, overrun_q;

  logic [BITSIZE-1:0]         cur_a, cur_b, a_mag, b_mag, op_a, op_b, wr_val;
  logic [1:0]                 cur_mode;
  logic                       op_sign;
  logic signed [2*BITSIZE:0]  p_signed;

  assign start   = s2_q & ~s3_q;
  assign last_ch = (ch_q == CH_W'(CHANNELS - 1));

  // lrclk synchroniser plus edge-detect delay flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.lrclk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state; LOAD kicks the shared core for the current channel.
  always_comb begin
    state_d   = state_q;
    umul_load = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        umul_load = 1'b1;
        state_d   = ST_MUL;
      end
      ST_MUL:     if (umul_done) state_d = ST_WRITE;
      ST_WRITE:   state_d = last_ch ? ST_PUBLISH : ST_LOAD;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operand formation and result shaping for the channel currently in the slot.
  always_comb begin
    cur_a    = in1_q[ch_q];
    cur_b    = in2_q[ch_q];
    cur_mode = mode_q[ch_q];
    a_mag    = cur_a[BITSIZE-1] ? ('0 - cur_a) : cur_a;
    b_mag    = cur_b[BITSIZE-1] ? ('0 - cur_b) : cur_b;
    op_a     = '0;
    op_b     = '0;
    op_sign  = 1'b0;
    case (cur_mode)
      MODE_RING: begin
        op_a    = a_mag;
        op_b    = b_mag;
        op_sign = cur_a[BITSIZE-1] ^ cur_b[BITSIZE-1];
      end
      MODE_AM: begin
        op_a    = {~cur_a[BITSIZE-1], cur_a[BITSIZE-2:0]};
        op_b    = b_mag;
        op_sign = cur_b[BITSIZE-1];
      end
      default: ;
    endcase
    p_signed = op_sign ? -$signed({1'b0, product}) : $signed({1'b0, product});
    wr_val   = '0;
    case (cur_mode)
      MODE_RING: begin
        if ((p_signed >>> (BITSIZE-1)) > SAT_MAX)      wr_val = SAT_MAX[BITSIZE-1:0];
        else if ((p_signed >>> (BITSIZE-1)) < SAT_MIN) wr_val = SAT_MIN[BITSIZE-1:0];
        else                                           wr_val = p_signed[2*BITSIZE-2:BITSIZE-1];
      end
      MODE_AM:     wr_val = p_signed[2*BITSIZE-1:BITSIZE];
      MODE_BYPASS: wr_val = cur_b;
      default:     wr_val = '0;
    endcase
  end

  // Snapshot, per-channel result store, atomic publish and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in1_q       <= '0;
      in2_q       <= '0;
      mode_q      <= '0;
      res_q       <= '0;
      ch_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        in1_q  <= bus.in1;
        in2_q  <= bus.in2;
        mode_q <= bus.mode;
        ch_q   <= '0;
      end
      if (state_q == ST_WRITE) begin
        res_q[ch_q] <= wr_val;
        if (!last_ch) ch_q <= ch_q + CH_W'(1);
      end
      out_valid_q <= (state_q == ST_PUBLISH);
      if (state_q == ST_PUBLISH) out_q <= res_q;
      if (start && state_q != ST_IDLE) overrun_q <= 1'b1;
      else if (bus.clear_overrun)      overrun_q <= 1'b0;
    end
  end

  serial_umul #(.BITSIZE(BITSIZE)) u_umul (
    .clk     (clk),
    .reset   (reset),
    .load    (umul_load),
    .a       (op_a),
    .b       (op_b),
    .done    (umul_done),
    .product (product)
  );

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_multiplier_tdm.sv
// Scoreboard bench for multiplier_tdm: directed frames push expected outputs, a monitor checks them.
module tb_multiplier_tdm;
  localparam int BITSIZE  = 16;
  localparam int CHANNELS = 2;
  localparam int W        = BITSIZE * CHANNELS;
  localparam int LAT      = 37;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  multiplier_tdm_if #(.BITSIZE(BITSIZE), .CHANNELS(CHANNELS)) bus ();

  multiplier_tdm #(.BITSIZE(BITSIZE), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_exp  = 0;
  int n_seen = 0;
  int cyc    = 0;
  int busy_cyc = 0;
  logic busy_prev = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: tracks busy rise and checks every published frame against the scoreboard.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        busy_prev = 1'b0;
      end else begin
        if (bus.busy && !busy_prev) busy_cyc = cyc;
        busy_prev = bus.busy;
        if (bus.out_valid) begin
          n_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out=%h with no frame expected", bus.out);
          end else begin
            e = exp_q.pop_front();
            chk("frame_out", 64'(bus.out), 64'(e));
            chk("latency", 64'(cyc - busy_cyc), 64'(LAT));
          end
        end
      end
    end
  end

  task automatic wait_seen(input string name);
    for (int i = 0; i < 200; i++) begin
      if (n_seen >= n_exp) begin
        repeat (3) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got %0d frames expected %0d", name, n_seen, n_exp);
  endtask

  task automatic wait_busy(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic run_frame(input string name, input logic [W-1:0] i1, input logic [W-1:0] i2,
                           input logic [2*CHANNELS-1:0] m, input logic [W-1:0] e);
    bus.in1  = i1;
    bus.in2  = i2;
    bus.mode = m;
    exp_q.push_back(e);
    n_exp++;
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.lrclk = 1'b0;
    wait_seen(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.lrclk = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.mode = '0;
    bus.clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);

    // Ring products, including negative operand.
    run_frame("ring", {16'h4000, 16'h4000}, {16'hC000, 16'h4000}, 4'b0000, {16'hE000, 16'h2000});
    // Ring saturation and the near-minimum product.
    run_frame("ring_sat", {16'h8000, 16'h8000}, {16'h7FFF, 16'h8000}, 4'b0000, {16'h8001, 16'h7FFF});
    // AM with offset-binary carrier.
    run_frame("am", {16'h7FFF, 16'h0000}, {16'h8000, 16'h7FFF}, 4'b0101, {16'h8000, 16'h3FFF});

    // Bypass/mute with inputs changed mid-frame.
    bus.in1  = {16'h1111, 16'h2222};
    bus.in2  = {16'h5555, 16'h1234};
    bus.mode = 4'b1110;
    exp_q.push_back({16'h0000, 16'h1234});
    n_exp++;
    bus.lrclk = 1'b1;
    wait_busy("bypass_busy");
    repeat (5) @(negedge clk);
    bus.lrclk = 1'b0;
    bus.in1  = {16'h7777, 16'h7777};
    bus.in2  = {16'h7777, 16'h7777};
    bus.mode = 4'b0000;
    wait_seen("bypass");

    // Overrun: second frame clock 10 cycles after the first; floor of -1 and near-max ring.
    bus.in1  = {16'h7FFF, 16'hFFFF};
    bus.in2  = {16'h7FFF, 16'h0001};
    bus.mode = 4'b0000;
    exp_q.push_back({16'h7FFE, 16'hFFFF});
    n_exp++;
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.lrclk = 1'b0;
    repeat (6) @(negedge clk);
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.lrclk = 1'b0;
    chk("overrun_set", 64'(bus.overrun), 64'd1);
    wait_seen("overrun_frame");
    chk("overrun_sticky", 64'(bus.overrun), 64'd1);
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.clear_overrun = 1'b0;
    chk("overrun_clear", 64'(bus.overrun), 64'd0);

    // Start-while-busy coinciding with clear: set wins.
    bus.in1  = {16'h0000, 16'hC000};
    bus.in2  = {16'h8000, 16'h4000};
    bus.mode = 4'b1001;
    exp_q.push_back({16'h8000, 16'h1000});
    n_exp++;
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.lrclk = 1'b0;
    repeat (6) @(negedge clk);
    bus.lrclk = 1'b1;
    repeat (2) @(negedge clk);
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.clear_overrun = 1'b0;
    chk("overrun_set_wins", 64'(bus.overrun), 64'd1);
    repeat (2) @(negedge clk);
    bus.lrclk = 1'b0;
    wait_seen("set_wins_frame");

    // Reset in the middle of channel 1's multiply, then a clean frame.
    bus.in1  = {16'h1234, 16'h4321};
    bus.in2  = {16'h1111, 16'h2222};
    bus.mode = 4'b0000;
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.lrclk = 1'b0;
    repeat (21) @(negedge clk);
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset_out", 64'(bus.out), 64'd0);
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_overrun", 64'(bus.overrun), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame("post_reset", {16'hE000, 16'h2000}, {16'h2000, 16'h2000}, 4'b0000, {16'hF800, 16'h0800});
    chk("post_reset_overrun", 64'(bus.overrun), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
